// File: rtl/lsu_align_seq.sv
// -----------------------------------------------------------------------------
// lsu_align_seq
//   Load/store sequencer placed directly in front of the data memory. It takes
//   one CPU request at a time over a valid/ready handshake. An aligned access
//   goes to the memory as a single access. A misaligned half or word access is
//   split into byte accesses (lbu/sb), because the memory cannot do that
//   itself. Load bytes are merged into one word and then sign- or
//   zero-extended. Each request gets exactly one response pulse.
//
// Ports
//   clk, rstn            clock, asynchronous active-low reset
//   req_valid/req_ready  request handshake (ready is high only in IDLE)
//   req_addr/req_wdata   byte address, right-aligned store data
//   req_memop/req_we     000 b, 001 h, 010 w, 100 bu, 101 hu; 1 = store
//   mem_addr/mem_datain  registered DataMem address / write data
//   mem_memop/mem_we     registered DataMem op / write enable
//   mem_dataout          DataMem read data, one cycle after mem_addr
//   rsp_valid            one-cycle response pulse, no backpressure
//   rsp_rdata            load result (0 for stores and errors)
//   rsp_err              request had an unsupported memop
//   rsp_split            request was executed as byte accesses
// -----------------------------------------------------------------------------
module lsu_align_seq #(
  parameter int unsigned RD_LAT = 1
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [2:0]  req_memop,
  input  logic        req_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_datain,
  output logic [2:0]  mem_memop,
  output logic        mem_we,
  input  logic [31:0] mem_dataout,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic        rsp_split
);

  // The CAPT state assumes that read data returns exactly one cycle after the
  // address, so other read latencies are rejected at elaboration.
  if (RD_LAT != 1) begin : g_rd_lat_unsupported
    $error("lsu_align_seq: only RD_LAT=1 is supported");
  end

  localparam logic [2:0] OP_SB  = 3'b000;
  localparam logic [2:0] OP_LBU = 3'b100;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_CAPT,
    S_RESP
  } state_e;

  // ---------------------------------------------------------------------------
  // State and registered outputs
  // ---------------------------------------------------------------------------
  state_e      state_q,      state_d;
  logic [1:0]  idx_q,        idx_d;       // current access within a request
  logic [1:0]  last_idx_q,   last_idx_d;  // K-1
  logic [31:0] addr_q,       addr_d;
  logic [31:0] wdata_q,      wdata_d;
  logic [2:0]  memop_q,      memop_d;
  logic        we_q,         we_d;
  logic        split_q,      split_d;
  logic [31:0] merge_q,      merge_d;     // bytes collected by split loads

  logic        req_ready_q,  req_ready_d;
  logic [31:0] mem_addr_q,   mem_addr_d;
  logic [31:0] mem_datain_q, mem_datain_d;
  logic [2:0]  mem_memop_q,  mem_memop_d;
  logic        mem_we_q,     mem_we_d;
  logic        rsp_valid_q,  rsp_valid_d;
  logic [31:0] rsp_rdata_q,  rsp_rdata_d;
  logic        rsp_err_q,    rsp_err_d;
  logic        rsp_split_q,  rsp_split_d;

  // ---------------------------------------------------------------------------
  // Classification of the incoming request (only used in IDLE)
  // ---------------------------------------------------------------------------
  logic       req_err;
  logic       req_split;
  logic [1:0] req_last_idx;

  always_comb begin
    // Unsupported: size code 11, 110, or an unsigned op used as a store.
    req_err   = (req_memop[1:0] == 2'b11) ||
                (req_memop[2] && (req_memop[1] || req_we));
    // Byte ops can never be misaligned.
    req_split = ((req_memop[1:0] == 2'b01) && req_addr[0]) ||
                ((req_memop[1:0] == 2'b10) && (req_addr[1:0] != 2'b00));
    if (!req_split) begin
      req_last_idx = 2'd0;
    end else if (req_memop[1:0] == 2'b01) begin
      req_last_idx = 2'd1;
    end else begin
      req_last_idx = 2'd3;
    end
  end

  // ---------------------------------------------------------------------------
  // Load data merge and final extension
  // ---------------------------------------------------------------------------
  logic [31:0] merged;
  logic [31:0] load_result;

  always_comb begin
    // NOTE: every variable assigned in a combinational block gets a default
    // first; a path that skips an assignment would otherwise infer a latch.
    merged = merge_q;
    merged[{idx_q, 3'b000} +: 8] = mem_dataout[7:0];

    load_result = merged;
    if (!split_q) begin
      // Single aligned access: the memory has already extended the data.
      load_result = mem_dataout;
    end else if (memop_q[1:0] == 2'b01) begin
      load_result = memop_q[2] ? {16'h0000, merged[15:0]}
                               : {{16{merged[15]}}, merged[15:0]};
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state and next-output logic
  // ---------------------------------------------------------------------------
  logic [1:0] idx_nxt;
  assign idx_nxt = idx_q + 2'd1;

  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    last_idx_d   = last_idx_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    memop_d      = memop_q;
    we_d         = we_q;
    split_d      = split_q;
    merge_d      = merge_q;
    mem_addr_d   = mem_addr_q;
    mem_datain_d = mem_datain_q;
    mem_memop_d  = mem_memop_q;
    mem_we_d     = 1'b0;          // write enable pulses only while issuing stores
    rsp_valid_d  = 1'b0;
    rsp_rdata_d  = rsp_rdata_q;   // result and split flag hold until next RESP
    rsp_err_d    = 1'b0;
    rsp_split_d  = rsp_split_q;

    unique case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          addr_d     = req_addr;
          wdata_d    = req_wdata;
          memop_d    = req_memop;
          we_d       = req_we;
          split_d    = req_split;
          last_idx_d = req_last_idx;
          idx_d      = 2'd0;
          merge_d    = 32'h0;
          if (req_err) begin
            // No memory access at all: answer straight away.
            state_d     = S_RESP;
            rsp_valid_d = 1'b1;
            rsp_err_d   = 1'b1;
            rsp_rdata_d = 32'h0;
            rsp_split_d = 1'b0;
          end else begin
            state_d      = S_ISSUE;
            mem_addr_d   = req_addr;
            mem_datain_d = req_wdata;
            mem_memop_d  = req_split ? (req_we ? OP_SB : OP_LBU) : req_memop;
            mem_we_d     = req_we;
          end
        end
      end

      S_ISSUE: begin
        if (!we_q) begin
          // Load: address is held while the read data comes back.
          state_d = S_CAPT;
        end else if (idx_q == last_idx_q) begin
          state_d     = S_RESP;
          rsp_valid_d = 1'b1;
          rsp_rdata_d = 32'h0;
          rsp_split_d = split_q;
        end else begin
          // Next byte of a split store; only split requests get here.
          idx_d        = idx_nxt;
          mem_addr_d   = addr_q + {30'h0, idx_nxt};
          mem_datain_d = wdata_q >> {idx_nxt, 3'b000};
          mem_memop_d  = OP_SB;
          mem_we_d     = 1'b1;
        end
      end

      S_CAPT: begin
        merge_d = merged;
        if (idx_q == last_idx_q) begin
          state_d     = S_RESP;
          rsp_valid_d = 1'b1;
          rsp_rdata_d = load_result;
          rsp_split_d = split_q;
        end else begin
          state_d      = S_ISSUE;
          idx_d        = idx_nxt;
          mem_addr_d   = addr_q + {30'h0, idx_nxt};
          mem_datain_d = wdata_q >> {idx_nxt, 3'b000};
          mem_memop_d  = OP_LBU;
        end
      end

      S_RESP: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase

    req_ready_d = (state_d == S_IDLE);
  end

  // ---------------------------------------------------------------------------
  // Registers. Reset is asynchronous so mem_we drops without a clock edge;
  // bytes already written by an interrupted request stay written.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q      <= S_IDLE;
      idx_q        <= 2'd0;
      last_idx_q   <= 2'd0;
      addr_q       <= 32'h0;
      wdata_q      <= 32'h0;
      memop_q      <= 3'b000;
      we_q         <= 1'b0;
      split_q      <= 1'b0;
      merge_q      <= 32'h0;
      req_ready_q  <= 1'b1;
      mem_addr_q   <= 32'h0;
      mem_datain_q <= 32'h0;
      mem_memop_q  <= 3'b000;
      mem_we_q     <= 1'b0;
      rsp_valid_q  <= 1'b0;
      rsp_rdata_q  <= 32'h0;
      rsp_err_q    <= 1'b0;
      rsp_split_q  <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments here so every register samples the
      // pre-edge values, independent of statement order.
      state_q      <= state_d;
      idx_q        <= idx_d;
      last_idx_q   <= last_idx_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      memop_q      <= memop_d;
      we_q         <= we_d;
      split_q      <= split_d;
      merge_q      <= merge_d;
      req_ready_q  <= req_ready_d;
      mem_addr_q   <= mem_addr_d;
      mem_datain_q <= mem_datain_d;
      mem_memop_q  <= mem_memop_d;
      mem_we_q     <= mem_we_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_rdata_q  <= rsp_rdata_d;
      rsp_err_q    <= rsp_err_d;
      rsp_split_q  <= rsp_split_d;
    end
  end

  assign req_ready  = req_ready_q;
  assign mem_addr   = mem_addr_q;
  assign mem_datain = mem_datain_q;
  assign mem_memop  = mem_memop_q;
  assign mem_we     = mem_we_q;
  assign rsp_valid  = rsp_valid_q;
  assign rsp_rdata  = rsp_rdata_q;
  assign rsp_err    = rsp_err_q;
  assign rsp_split  = rsp_split_q;

endmodule
